// File: rtl/pipe_stage_skid_pkg.sv
// pipe_pkg: definitions shared by the pipeline stage register and its
// helpers.
//   - Occupancy encodings for the 2-entry skid stage.
//   - Default payload width and the bubble (NOP) payload.
//   - Default performance counter width.
//   - A helper that maps the two entry valid bits to an occupancy code.
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int DEFAULT_DATA_W = 128;
  localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_NOP = '0;
  localparam int DEFAULT_CNT_W  = 32;

  // The skid entry is only ever valid behind a valid main entry, so
  // {s_valid=1, m_valid=0} cannot occur.  It is mapped to ONE so that the
  // function is total.
  function automatic logic [1:0] occ_of(input logic m_valid, input logic s_valid);
    logic [1:0] occ;
    case ({m_valid, s_valid})
      2'b00:   occ = OCC_EMPTY;
      2'b11:   occ = OCC_FULL;
      default: occ = OCC_ONE;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// sat_counter: free-running event counter that saturates at all-ones.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset, clears the count
//   inc   - count one event on this clock edge
//   count - current count value (W bits)
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    // Stick at all-ones; the counter must never wrap back to zero.
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with a 2-entry skid
// buffer, flush with delay-slot survival, bubble injection, and
// starvation/back-pressure counters.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   flush             - discard every entry that does not have keep set
//   in_valid/in_ready - upstream handshake (in_ready is registered)
//   in_data, in_keep  - upstream payload and its survive-flush flag
//   out_valid/out_ready - downstream handshake (out_valid is registered)
//   out_data          - head payload, or NOP_VALUE when empty
//   occupancy         - number of valid entries (0..2)
//   bubble_cnt        - cycles the downstream was ready but starved
//   stall_cnt         - cycles the downstream held off a valid payload
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int                CNT_W     = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Main (head) entry and skid entry.
  logic              m_valid_q, m_valid_d;
  logic              m_keep_q,  m_keep_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic              s_keep_q,  s_keep_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;

  logic accept;
  logic fire;

  // Ordered candidates for next-cycle storage: [0] head left after the
  // fire, [1] skid left after the fire, [2] accepted input.
  logic [2:0]        cand_v;
  logic [2:0]        cand_k;
  logic [DATA_W-1:0] cand_d [3];
  logic [2:0]        survive;

  assign accept = in_valid & in_ready & ~rst;
  assign fire   = out_valid & out_ready;

  always_comb begin
    // When the head fires, the skid entry moves up to candidate 0.
    cand_v[0] = fire ? s_valid_q : m_valid_q;
    cand_k[0] = fire ? s_keep_q  : m_keep_q;
    cand_d[0] = fire ? s_data_q  : m_data_q;
    cand_v[1] = s_valid_q & ~fire;
    cand_k[1] = s_keep_q;
    cand_d[1] = s_data_q;
    cand_v[2] = accept;
    cand_k[2] = in_keep;
    cand_d[2] = in_data;
  end

  // Outside a flush every live candidate survives; during a flush only those
  // marked keep survive.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_survive
      assign survive[gi] = cand_v[gi] & (~flush | cand_k[gi]);
    end
  endgenerate

  // Compact the survivors in order into M then S.  At most two candidates
  // are ever live because a full stage cannot accept, so nothing is lost.
  always_comb begin
    m_valid_d = 1'b0;
    m_keep_d  = 1'b0;
    m_data_d  = NOP_VALUE;
    s_valid_d = 1'b0;
    s_keep_d  = 1'b0;
    s_data_d  = NOP_VALUE;
    for (int i = 0; i < 3; i++) begin
      if (survive[i]) begin
        if (!m_valid_d) begin
          m_valid_d = 1'b1;
          m_keep_d  = cand_k[i];
          m_data_d  = cand_d[i];
        end else if (!s_valid_d) begin
          s_valid_d = 1'b1;
          s_keep_d  = cand_k[i];
          s_data_d  = cand_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_keep_q  <= 1'b0;
      m_data_q  <= NOP_VALUE;
      s_valid_q <= 1'b0;
      s_keep_q  <= 1'b0;
      s_data_q  <= NOP_VALUE;
    end else begin
      m_valid_q <= m_valid_d;
      m_keep_q  <= m_keep_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_keep_q  <= s_keep_d;
      s_data_q  <= s_data_d;
    end
  end

  // All outputs come straight from registers.
  assign out_valid = m_valid_q;
  assign out_data  = m_valid_q ? m_data_q : NOP_VALUE;
  assign in_ready  = ~s_valid_q;
  assign occupancy = occ_of(m_valid_q, s_valid_q);

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (~m_valid_q & out_ready),
    .count(bubble_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (m_valid_q & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_keep;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] bubble_cnt;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid #(
    .DATA_W   (DW),
    .NOP_VALUE({DW{1'b0}}),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .bubble_cnt(bubble_cnt),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: an ordered queue of payloads --------
  typedef struct {
    logic          keep;
    logic [DW-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   exp_bubble = 0;
  int   exp_stall  = 0;
  bit   model_ok   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      exp_bubble = 0;
      exp_stall  = 0;
      model_ok   = 1'b1;
    end else begin
      bit   fire_m;
      bit   acc_m;
      ent_t e;
      ent_t kept[$];
      fire_m = (mq.size() > 0) && out_ready;
      acc_m  = in_valid && (mq.size() < 2);
      if ((mq.size() == 0) && out_ready && (exp_bubble < CMAX)) exp_bubble++;
      if ((mq.size() > 0) && !out_ready && (exp_stall < CMAX)) exp_stall++;
      if (fire_m) begin
        $display("xfer out data=%0h", mq[0].data);
        void'(mq.pop_front());
      end
      if (acc_m) begin
        e.keep = in_keep;
        e.data = in_data;
        mq.push_back(e);
        $display("xfer in  data=%0h keep=%0b flush=%0b", in_data, in_keep, flush);
      end
      if (flush) begin
        kept.delete();
        foreach (mq[i]) if (mq[i].keep) kept.push_back(mq[i]);
        mq = kept;
      end
    end
  end

  // Compare every cycle on the falling edge once reset has been applied.
  always @(negedge clk) begin
    if (model_ok) begin
      logic [DW-1:0] exp_data;
      exp_data = '0;
      if (mq.size() > 0) exp_data = mq[0].data;
      check("out_valid",  out_valid,  mq.size() > 0);
      check("out_data",   out_data,   exp_data);
      check("in_ready",   in_ready,   mq.size() < 2);
      check("occupancy",  occupancy,  mq.size());
      check("bubble_cnt", bubble_cnt, exp_bubble);
      check("stall_cnt",  stall_cnt,  exp_stall);
    end
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic k,
                       input logic fl, input logic rdy);
    in_valid  = v;
    in_data   = d;
    in_keep   = k;
    flush     = fl;
    out_ready = rdy;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with a live input that must be ignored.
    rst = 1'b1;
    drive(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("lit_rst_out_valid", out_valid, 0);
    check("lit_rst_in_ready",  in_ready,  1);
    check("lit_rst_occ",       occupancy, 0);
    check("lit_rst_out_data",  out_data,  0);
    check("lit_rst_bubble",    bubble_cnt, 0);
    check("lit_rst_stall",     stall_cnt, 0);
    rst = 1'b0;

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
      tick();
      check("lit_stream_data", out_data, i);
      check("lit_stream_occ",  occupancy, 1);
      check("lit_stream_rdy",  in_ready, 1);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    check("lit_stream_drain", out_valid, 0);

    // Back-pressure: A then B held, then released in order.
    do_reset();
    drive(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    tick();
    check("lit_bp_occ",    occupancy, 2);
    check("lit_bp_rdy",    in_ready, 0);
    check("lit_bp_stall1", stall_cnt, 1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("lit_bp_stall3", stall_cnt, 3);
    check("lit_bp_head",   out_data, 32'h11);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    check("lit_bp_second", out_data, 32'h22);
    check("lit_bp_occ1",   occupancy, 1);
    tick();
    check("lit_bp_empty",  occupancy, 0);

    // Flush from FULL: keep A, drop B.
    do_reset();
    drive(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    check("lit_fl_occ",  occupancy, 1);
    check("lit_fl_data", out_data, 32'h11);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    check("lit_fl_empty", occupancy, 0);
    check("lit_fl_nop",   out_data, 0);

    // Flush from ONE together with a keep input.
    do_reset();
    drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h44, 1'b1, 1'b1, 1'b0);
    tick();
    check("lit_flin_occ",  occupancy, 1);
    check("lit_flin_data", out_data, 32'h44);
    // Head fires and a non-keep input is consumed and dropped by the flush.
    drive(1'b1, 32'h55, 1'b0, 1'b1, 1'b1);
    tick();
    check("lit_fldrop_occ", occupancy, 0);

    // Flush while firing: the kept skid entry moves to the head.
    do_reset();
    drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    check("lit_flfire_data", out_data, 32'h77);
    check("lit_flfire_occ",  occupancy, 1);

    // Mid-stream reset from FULL with an input present.
    drive(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'hAB, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("lit_midrst_occ",   occupancy, 0);
    check("lit_midrst_valid", out_valid, 0);

    // Mixed traffic pattern, checked by the model each cycle.
    for (int i = 0; i < 40; i++) begin
      drive((i % 3) != 0, 32'h100 + DW'(i), (i % 2) == 1, (i % 11) == 7, (i % 4) != 1);
      tick();
    end

    // Counter saturation.
    do_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (20) tick();
    check("lit_sat_bubble", bubble_cnt, 15);
    check("lit_sat_stall",  stall_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshake-based pipeline stage register with a 2-entry skid buffer. It replaces the fixed-field stall-vector stage registers between IF/ID/EX/MEM/WB.
- The payload is an opaque DATA_W bus, so every stage boundary (op, sel, operands, write addr/en, link addr, delay-slot flags, inst word) is one instance.
- Adds valid/ready flow control, flush with delay-slot survival, bubble injection, and stall/bubble performance counters.

Parameters:
- DATA_W, 128, payload width in bits.
- NOP_VALUE, {DATA_W{1'b0}}, payload presented on out_data when no valid entry exists (bubble encoding).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- flush  in  1  kill non-surviving entries this cycle.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload.
- in_data  in  DATA_W  upstream payload.
- in_keep  in  1  payload survives a flush (delay-slot instruction).
- out_valid  out  1  out_data holds a real payload.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  DATA_W  head payload, or NOP_VALUE.
- occupancy  out  2  number of valid entries (0..2).
- bubble_cnt  out  CNT_W  cycles the downstream was starved.
- stall_cnt  out  CNT_W  cycles the downstream back-pressured.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Storage:
  - Main entry M (valid, keep, data) and skid entry S (valid, keep, data).
  - Order is FIFO: M is the head; S is only valid when M is valid.
- Output derivation (all outputs are functions of registers only; no combinational input-to-output path):
  - out_valid = M.valid.
  - out_data = M.valid ? M.data : NOP_VALUE.
  - in_ready = !S.valid.
  - occupancy = M.valid + S.valid.
- Events:
  - accept = in_valid & in_ready & !rst.
  - fire = out_valid & out_ready.
- States:
  - EMPTY (occupancy 0), ONE (1), FULL (2).
  - The state is implied by the valid bits; no separate state register.
- Transitions when flush=0:
  - EMPTY: accept -> ONE, M<=in.
  - ONE: accept & fire -> ONE, M<=in. accept & !fire -> FULL, S<=in. fire & !accept -> EMPTY. Neither -> hold.
  - FULL: no accept is possible. fire -> ONE, M<=S, S cleared. Otherwise hold.
- Flush (flush=1), with priority over normal transitions:
  - First, remove the entry that fires this cycle.
  - Candidates, in order: remaining M, remaining S, accepted input.
  - Keep only candidates with keep=1 and compact them in order into M, then S. Others are discarded.
  - At most 2 candidates exist, because FULL implies in_ready=0.
  - in_ready is not gated by flush. A non-keep input accepted on a flush cycle is consumed and dropped.
- Data hygiene: invalidated or discarded entries have their data registers written to NOP_VALUE.
- Counters (saturating at all-ones, never wrap):
  - bubble_cnt += 1 when !out_valid & out_ready.
  - stall_cnt += 1 when out_valid & !out_ready.
  - Both counters are cleared only by rst.
- Reset (rst=1 at clk edge), taking priority over flush and handshakes:
  - M and S become invalid, keep bits 0, data registers NOP_VALUE.
  - Counters 0.
- Outputs after the reset edge: out_valid=0, in_ready=1, out_data=NOP_VALUE, occupancy=0.
- Inputs presented during rst are ignored, including a mid-stream reset with FULL occupancy.
- Latency and throughput:
  - A payload accepted at edge N is visible on out_data after edge N when the stage was EMPTY, or when ONE and firing.
  - Sustained throughput is 1 payload/cycle with out_ready=1.
- No payload may be lost or duplicated except by flush or rst.

Decomposition:
- Shared package pipe_pkg: occupancy encodings (OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2), default NOP payload constant, default counter width.
- Sub-module sat_counter (parameter W, inputs clk/rst/inc, output count), instantiated twice for bubble_cnt and stall_cnt.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xAA -> after release out_valid=0, in_ready=1, occupancy=0, out_data=0, both counters 0.
- Streaming: out_ready=1; push 1..8 on consecutive cycles -> out_data shows 1..8 on consecutive cycles starting the cycle after the first accept, in_ready stays 1, occupancy=1.
- Backpressure: out_ready=0; push A=0x11, then B=0x22 -> occupancy=2, in_ready=0, stall_cnt increments each held cycle. Raise out_ready -> A, then B, with no duplication.
- Flush with keep: FULL with M=A (keep=1), S=B (keep=0); flush=1, out_ready=0 -> next cycle occupancy=1, out_data=A. Fire -> EMPTY, out_data=NOP_VALUE.
- Flush with keep input: ONE with M=C (keep=0), out_ready=0; flush=1 together with accept of D=0x44 (keep=1) -> next cycle M=D, occupancy=1.
- Saturation: CNT_W=4, in_valid=0, out_ready=1 for 20 cycles -> bubble_cnt=15, stall_cnt=0.
